// File: rtl/seg7_digit_rx_pkg.sv
// Shared types for the 7-segment receiver; SEG7_RX_HEX_EN widens decode to hex.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
`include "seg7_defs.vh"

package seg7_digit_rx_pkg;

    localparam int SEG_W = 8;

    typedef enum logic {
        ST_WAIT = `SEG7_ST_WAIT,
        ST_PEND = `SEG7_ST_PEND
    } state_t;

    typedef struct packed {
        logic       hit;
        logic       blank;
        logic [3:0] digit;
    } cls_t;

    function automatic logic [SEG_W-1:0] normalise(input logic [SEG_W-1:0] pins,
                                                   input bit               active_low);
        return active_low ? ~pins : pins;
    endfunction

endpackage

// File: rtl/seg7_classify.sv
// Maps an active-high abcdefg pattern to {hit, blank, digit}; SEG7_RX_HEX_EN adds A..F.
// Latency: combinational.
// Backpressure: none.
`include "seg7_defs.vh"

module seg7_classify
    import seg7_digit_rx_pkg::*;
(
    input  logic [6:0] seg,
    output cls_t       cls
);

    always_comb begin
        cls.hit   = 1'b1;
        cls.blank = 1'b0;
        cls.digit = 4'd0;
        case (seg)
            `SEG7_PAT_0: cls.digit = 4'd0;
            `SEG7_PAT_1: cls.digit = 4'd1;
            `SEG7_PAT_2: cls.digit = 4'd2;
            `SEG7_PAT_3: cls.digit = 4'd3;
            `SEG7_PAT_4: cls.digit = 4'd4;
            `SEG7_PAT_5: cls.digit = 4'd5;
            `SEG7_PAT_6: cls.digit = 4'd6;
            `SEG7_PAT_7: cls.digit = 4'd7;
            `SEG7_PAT_8: cls.digit = 4'd8;
            `SEG7_PAT_9: cls.digit = 4'd9;
`ifdef SEG7_RX_HEX_EN
            `SEG7_PAT_A: cls.digit = 4'd10;
            `SEG7_PAT_B: cls.digit = 4'd11;
            `SEG7_PAT_C: cls.digit = 4'd12;
            `SEG7_PAT_D: cls.digit = 4'd13;
            `SEG7_PAT_E: cls.digit = 4'd14;
            `SEG7_PAT_F: cls.digit = 4'd15;
`endif
            `SEG7_PAT_BLANK: begin
                cls.hit   = 1'b0;
                cls.blank = 1'b1;
            end
            default: cls.hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_defs.vh
// Segment patterns (active-high abcdefg) for digits 0..F and blank, plus FSM state encodings.
// Shared by the receiver package and the classifier.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

`define SEG7_PAT_0     7'b1111110
`define SEG7_PAT_1     7'b0110000
`define SEG7_PAT_2     7'b1101101
`define SEG7_PAT_3     7'b1111001
`define SEG7_PAT_4     7'b0110011
`define SEG7_PAT_5     7'b1011011
`define SEG7_PAT_6     7'b1011111
`define SEG7_PAT_7     7'b1110000
`define SEG7_PAT_8     7'b1111111
`define SEG7_PAT_9     7'b1111011
`define SEG7_PAT_A     7'b1110111
`define SEG7_PAT_B     7'b0011111
`define SEG7_PAT_C     7'b1001110
`define SEG7_PAT_D     7'b0111101
`define SEG7_PAT_E     7'b1001111
`define SEG7_PAT_F     7'b1000111
`define SEG7_PAT_BLANK 7'b0000000

`define SEG7_ST_WAIT   1'b0
`define SEG7_ST_PEND   1'b1

`endif

// File: rtl/seg7_digit_rx.sv
// Samples async segment pins, waits for a stable pattern and delivers each new digit once (SEG7_RX_HEX_EN: hex).
// Latency: STABLE_CYCLES+2 edges from a pin change to valid.
// Backpressure: digit held while ready=0; pins are ignored until the pending digit is taken.
`include "seg7_defs.vh"

module seg7_digit_rx
    import seg7_digit_rx_pkg::*;
#(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned STABLE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       dp,
    output logic [3:0] digit,
    output logic       dp_out,
    output logic       valid,
    input  logic       ready,
    output logic       err,
    output logic [7:0] err_seg
);

    localparam logic [7:0]       STABLE_MAX = 8'(STABLE_CYCLES);
    // Pin level that normalises to an all-dark pattern, so reset reads as blank.
    localparam logic [SEG_W-1:0] PINS_IDLE  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [SEG_W-1:0] BLANK8     = {`SEG7_PAT_BLANK, 1'b0};

    logic [SEG_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [SEG_W-1:0] marker_q, marker_d;
    state_t           state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             dp_out_q, dp_out_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [7:0]       err_seg_q, err_seg_d;

    logic [SEG_W-1:0] seg_s;
    logic             stable;
    cls_t             cls;

    seg7_classify u_classify (
        .seg (seg_s[7:1]),
        .cls (cls)
    );

    always_comb begin
        sync1_d = {a, b, c, d, e, f, g, dp};
        sync2_d = sync1_q;
        seg_s   = normalise(sync2_q, SEG_ACTIVE_LOW);

        // The sample arriving with a change is already the first of its run.
        if (sync1_q != sync2_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        stable = (cnt_q == STABLE_MAX);

        state_d   = state_q;
        marker_d  = marker_q;
        digit_d   = digit_q;
        dp_out_d  = dp_out_q;
        valid_d   = valid_q;
        err_d     = 1'b0;
        err_seg_d = err_seg_q;

        if (state_q == ST_PEND) begin
            if (ready) begin
                valid_d = 1'b0;
                state_d = ST_WAIT;
            end
        end else if (stable && (seg_s != marker_q)) begin
            if (cls.blank) begin
                marker_d = BLANK8;
            end else if (cls.hit) begin
                digit_d  = cls.digit;
                dp_out_d = seg_s[0];
                valid_d  = 1'b1;
                marker_d = seg_s;
                state_d  = ST_PEND;
            end else begin
                err_d     = 1'b1;
                err_seg_d = seg_s;
                marker_d  = seg_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= PINS_IDLE;
            sync2_q   <= PINS_IDLE;
            cnt_q     <= 8'd0;
            marker_q  <= BLANK8;
            state_q   <= ST_WAIT;
            digit_q   <= 4'd0;
            dp_out_q  <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            err_seg_q <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            marker_q  <= marker_d;
            state_q   <= state_d;
            digit_q   <= digit_d;
            dp_out_q  <= dp_out_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            err_seg_q <= err_seg_d;
        end
    end

    assign digit   = digit_q;
    assign dp_out  = dp_out_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign err_seg = err_seg_q;

endmodule

// File: tb/tb_seg7_digit_rx.sv
// Bench for seg7_digit_rx: directed scenarios plus randomized pattern runs against a table-driven model.
// Expected transfers/errors are queued at stimulus time and popped by an independent monitor.
module tb_seg7_digit_rx;

    localparam bit          SEG_ACTIVE_LOW = 1'b1;
    localparam int unsigned STABLE_CYCLES  = 4;
`ifdef SEG7_RX_HEX_EN
    localparam int NDIG = 16;
`else
    localparam int NDIG = 10;
`endif

    typedef struct {
        bit         is_err;
        logic [3:0] digit;
        logic       dp;
        logic [7:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] pins = 8'hFF;
    logic [3:0] digit;
    logic       dp_out, valid, err;
    logic [7:0] err_seg;

    int         checks = 0;
    int         errors = 0;
    exp_t       expq[$];
    exp_t       mon_e;
    bit         err_prev = 1'b0;
    logic [7:0] marker;

    logic [6:0] ref_tab [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    always #5 clk = ~clk;

    seg7_digit_rx #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
        .STABLE_CYCLES  (STABLE_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (pins[7]),
        .b       (pins[6]),
        .c       (pins[5]),
        .d       (pins[4]),
        .e       (pins[3]),
        .f       (pins[2]),
        .g       (pins[1]),
        .dp      (pins[0]),
        .digit   (digit),
        .dp_out  (dp_out),
        .valid   (valid),
        .ready   (ready),
        .err     (err),
        .err_seg (err_seg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic note_fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit lookup(input logic [6:0] s, output logic [3:0] dv);
        dv = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (ref_tab[i] == s) begin
                dv = 4'(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Reference behaviour for a pattern that has become stable.
    task automatic model_step(input logic [7:0] p);
        exp_t       x;
        logic [3:0] dv;
        if (p != marker) begin
            if (p[7:1] == 7'd0) begin
                marker = 8'h00;
            end else begin
                x.seg   = p;
                x.dp    = p[0];
                x.digit = 4'd0;
                if (lookup(p[7:1], dv)) begin
                    x.is_err = 1'b0;
                    x.digit  = dv;
                end else begin
                    x.is_err = 1'b1;
                end
                expq.push_back(x);
                marker = p;
            end
        end
    endtask

    task automatic show(input logic [7:0] p, input int cycles, input bit stable);
        pins = SEG_ACTIVE_LOW ? ~p : p;
        if (stable) model_step(p);
        repeat (cycles) tick();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            err_prev = 1'b0;
        end else begin
            if (err) begin
                chk("err_pulse_width", 32'(err_prev), 32'd0);
                if (expq.size() == 0) begin
                    note_fail("err_unexpected", $sformatf("err_seg %0h with nothing expected", err_seg));
                end else begin
                    mon_e = expq.pop_front();
                    if (!mon_e.is_err)
                        note_fail("err_kind", $sformatf("err_seg %0h but digit %0d expected", err_seg, mon_e.digit));
                    else
                        chk("err_seg", 32'(err_seg), 32'(mon_e.seg));
                end
            end
            err_prev = err;
            if (valid && ready) begin
                if (expq.size() == 0) begin
                    note_fail("xfer_unexpected", $sformatf("digit %0d dp %0b with nothing expected", digit, dp_out));
                end else begin
                    mon_e = expq.pop_front();
                    if (mon_e.is_err)
                        note_fail("xfer_kind", $sformatf("digit %0d but err %0h expected", digit, mon_e.seg));
                    else
                        chk("xfer_digit_dp", 32'({dp_out, digit}), 32'({mon_e.dp, mon_e.digit}));
                end
            end
        end
    end

    initial begin
        logic [7:0] p, prev_p;
        int         cyc, h;
        bit         st;

        // Reset with "5" already on the pins (dp pin inactive).
        marker = 8'h00;
        p = {ref_tab[5], 1'b0};
        pins = ~p;
        rst = 1'b1;
        ready = 1'b0;
        tick();
        tick();
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_dp_out", 32'(dp_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_seg", 32'(err_seg), 32'd0);
        rst = 1'b0;
        model_step(p);
        cyc = 0;
        while (!valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("latency_edges", 32'(cyc), 32'd6);
        ready = 1'b1;
        tick();
        chk("valid_drop_after_xfer", 32'(valid), 32'd0);

        // Backpressure: "3" waits while "8" appears behind it.
        ready = 1'b0;
        show({ref_tab[3], 1'b0}, 20, 1'b1);
        chk("pend3_valid", 32'(valid), 32'd1);
        chk("pend3_digit", 32'(digit), 32'd3);
        show({ref_tab[8], 1'b0}, 20, 1'b1);
        chk("held3_valid", 32'(valid), 32'd1);
        chk("held3_digit", 32'(digit), 32'd3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        chk("follow8_valid", 32'(valid), 32'd1);
        chk("follow8_digit", 32'(digit), 32'd8);
        ready = 1'b1;
        tick();

        // Repeat suppression, then blank re-arms the same digit.
        show({ref_tab[7], 1'b0}, 60, 1'b1);
        show(8'h00, 5, 1'b1);
        show({ref_tab[7], 1'b0}, 15, 1'b1);

        // Glitch shorter than the stability count is dropped.
        show({ref_tab[1], 1'b0}, 3, 1'b0);
        show({ref_tab[2], 1'b1}, 15, 1'b1);

        // Unrecognised pattern (g only).
        show(8'b0000_0010, 15, 1'b1);
        chk("err_seg_held", 32'(err_seg), 32'h02);
        chk("err_no_valid", 32'(valid), 32'd0);

        // "E": digit 14 with hex decode, error otherwise.
        show({ref_tab[14], 1'b0}, 15, 1'b1);

        // Randomized pattern runs, consumer always ready.
        prev_p = {ref_tab[14], 1'b0};
        for (int n = 0; n < 60; n++) begin
            cyc = int'($urandom_range(0, 7));
            if (cyc <= 5)      p = {ref_tab[$urandom_range(0, 15)], 1'b0};
            else if (cyc == 6) p = 8'h00;
            else               p = {7'($urandom_range(0, 127)), 1'b0};
            p[0] = 1'($urandom_range(0, 1));
            if (p == prev_p) p[0] = ~p[0];
            if ($urandom_range(0, 3) == 0) begin
                h  = int'($urandom_range(1, 3));
                st = 1'b0;
            end else begin
                h  = int'($urandom_range(8, 20));
                st = 1'b1;
            end
            show(p, h, st);
            prev_p = p;
        end

        cyc = 0;
        while (expq.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
